// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: two-source round-robin AXI-Stream arbiter.
// Packet-atomic grants, watchdog truncation, per-source packet counters.
module axis_packet_arbiter #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_PKT_LEN      = 256,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        rst,
  input  logic [AXIS_TDATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                        s0_axis_tvalid,
  output logic                        s0_axis_tready,
  input  logic                        s0_axis_tlast,
  input  logic [AXIS_TDATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                        s1_axis_tvalid,
  output logic                        s1_axis_tready,
  input  logic                        s1_axis_tlast,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tid,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        pkt_count0,
  output logic [CNT_WIDTH-1:0]        pkt_count1,
  output logic                        trunc_err
);

  localparam int BW = $clog2(MAX_PKT_LEN);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS0 = 2'd1;
  localparam logic [1:0] PASS1 = 2'd2;

  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_PKT_LEN - 1);
  localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic                 last_served_q, last_served_d;
  logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
  logic                 trunc_q, trunc_d;

  logic                        sel;
  logic                        granted;
  logic [AXIS_TDATA_WIDTH-1:0] src_tdata;
  logic                        src_tvalid;
  logic                        src_tlast;
  logic                        wd_hit;
  logic                        beat;
  logic                        pkt_end;

  // Mux the granted source straight through to the sink
  always_comb begin
    sel        = (state_q == PASS1);
    granted    = (state_q == PASS0) | (state_q == PASS1);
    src_tdata  = sel ? s1_axis_tdata  : s0_axis_tdata;
    src_tvalid = sel ? s1_axis_tvalid : s0_axis_tvalid;
    src_tlast  = sel ? s1_axis_tlast  : s0_axis_tlast;
    wd_hit     = (beat_cnt_q == LAST_BEAT);

    m_axis_tdata   = granted ? src_tdata : '0;
    m_axis_tvalid  = granted & src_tvalid;
    m_axis_tlast   = granted & (src_tlast | wd_hit);
    m_axis_tid     = sel;
    s0_axis_tready = (state_q == PASS0) & m_axis_tready;
    s1_axis_tready = (state_q == PASS1) & m_axis_tready;

    beat    = m_axis_tvalid & m_axis_tready;
    pkt_end = beat & m_axis_tlast;
  end

  // Arbitration, beat counting and end-of-packet bookkeeping
  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    beat_cnt_d    = beat_cnt_q;
    cnt0_d        = cnt0_q;
    cnt1_d        = cnt1_q;
    trunc_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s0_axis_tvalid & s1_axis_tvalid) begin
          state_d = last_served_q ? PASS0 : PASS1;
        end else if (s0_axis_tvalid) begin
          state_d = PASS0;
        end else if (s1_axis_tvalid) begin
          state_d = PASS1;
        end
      end
      PASS0, PASS1: begin
        if (pkt_end) begin
          state_d       = IDLE;
          beat_cnt_d    = '0;
          last_served_d = sel;
          trunc_d       = ~src_tlast;
          if (sel) begin
            cnt1_d = cnt1_q + CNT_ONE;
          end else begin
            cnt0_d = cnt0_q + CNT_ONE;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + BEAT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      beat_cnt_q    <= '0;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
      trunc_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      beat_cnt_q    <= beat_cnt_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      trunc_q       <= trunc_d;
    end
  end

  assign busy       = granted;
  assign pkt_count0 = cnt0_q;
  assign pkt_count1 = cnt1_q;
  assign trunc_err  = trunc_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: randomized bench with a beat-level reference
// model built from per-source stream arrays and grant ownership.
module tb_axis_packet_arbiter;

  localparam int DW   = 32;
  localparam int MAXL = 8;
  localparam int CW   = 4;
  localparam int CMOD = 1 << CW;

  logic          aclk = 1'b0;
  logic          rst;
  logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic          m_axis_tid, busy, trunc_err;
  logic [CW-1:0] pkt_count0, pkt_count1;

  axis_packet_arbiter #(
    .AXIS_TDATA_WIDTH(DW),
    .MAX_PKT_LEN(MAXL),
    .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .rst(rst),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tready(s0_axis_tready), .s0_axis_tlast(s0_axis_tlast),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tready(s1_axis_tready), .s1_axis_tlast(s1_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .busy(busy),
    .pkt_count0(pkt_count0), .pkt_count1(pkt_count1),
    .trunc_err(trunc_err)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] sd [2][512];
  bit            sl [2][512];
  int            slen [2];
  int            idx [2];
  int            eidx [2];
  bit            hs [2];

  int m_owner, m_last, m_pos, m_cnt0, m_cnt1;
  bit m_trunc;
  int tpulse, phase_beats;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_pos   = 0;
    m_cnt0  = 0;
    m_cnt1  = 0;
    m_trunc = 1'b0;
  endtask

  // plen > 0: fixed packet length; 0: never tlast; < 0: random lengths
  task automatic load(int x, int n, int plen, int base);
    int rem;
    rem = 0;
    for (int i = 0; i < n; i++) begin
      sd[x][i] = (base >= 0) ? DW'(base + i) : $urandom;
      if (plen > 0) begin
        sl[x][i] = ((i + 1) % plen) == 0;
      end else if (plen == 0) begin
        sl[x][i] = 1'b0;
      end else begin
        if (rem == 0) rem = $urandom_range(12, 1);
        rem--;
        sl[x][i] = (rem == 0) || (i == n - 1);
      end
    end
    slen[x] = n;
    idx[x]  = 0;
    eidx[x] = 0;
  endtask

  task automatic drive(int pv0, int pv1, int pr);
    bit v0, v1;
    v0 = (idx[0] < slen[0]) && (int'($urandom_range(99)) < pv0);
    v1 = (idx[1] < slen[1]) && (int'($urandom_range(99)) < pv1);
    s0_axis_tvalid = v0;
    s0_axis_tdata  = (idx[0] < slen[0]) ? sd[0][idx[0]] : '0;
    s0_axis_tlast  = (idx[0] < slen[0]) ? sl[0][idx[0]] : 1'b0;
    s1_axis_tvalid = v1;
    s1_axis_tdata  = (idx[1] < slen[1]) ? sd[1][idx[1]] : '0;
    s1_axis_tlast  = (idx[1] < slen[1]) ? sl[1][idx[1]] : 1'b0;
    m_axis_tready  = int'($urandom_range(99)) < pr;
  endtask

  task automatic observe();
    int x;
    bit sv, own_r, oth_r, ex_last, src_last, trunc_n;
    chk("busy", 64'(busy), 64'(m_owner != -1));
    chk("trunc_err", 64'(trunc_err), 64'(m_trunc));
    chk("pkt_count0", 64'(pkt_count0), 64'(m_cnt0));
    chk("pkt_count1", 64'(pkt_count1), 64'(m_cnt1));
    if (trunc_err) tpulse++;
    hs[0] = s0_axis_tvalid & s0_axis_tready;
    hs[1] = s1_axis_tvalid & s1_axis_tready;
    trunc_n = 1'b0;
    if (m_owner < 0) begin
      chk("idle_tready", 64'({s0_axis_tready, s1_axis_tready}), 64'(0));
      chk("idle_tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("idle_tdata", 64'(m_axis_tdata), 64'(0));
      chk("idle_tid", 64'(m_axis_tid), 64'(0));
      if (s0_axis_tvalid && s1_axis_tvalid) m_owner = 1 - m_last;
      else if (s0_axis_tvalid) m_owner = 0;
      else if (s1_axis_tvalid) m_owner = 1;
    end else begin
      x     = m_owner;
      sv    = x ? s1_axis_tvalid : s0_axis_tvalid;
      own_r = x ? s1_axis_tready : s0_axis_tready;
      oth_r = x ? s0_axis_tready : s1_axis_tready;
      chk("tid", 64'(m_axis_tid), 64'(x));
      chk("tvalid", 64'(m_axis_tvalid), 64'(sv));
      chk("tready_own", 64'(own_r), 64'(m_axis_tready));
      chk("tready_other", 64'(oth_r), 64'(0));
      if (m_axis_tvalid && m_axis_tready) begin
        if (eidx[x] >= slen[x]) begin
          chk("extra_beat", 64'(eidx[x]), 64'(slen[x] - 1));
        end else begin
          src_last = sl[x][eidx[x]];
          ex_last  = src_last || (m_pos + 1 == MAXL);
          chk("tdata", 64'(m_axis_tdata), 64'(sd[x][eidx[x]]));
          chk("tlast", 64'(m_axis_tlast), 64'(ex_last));
          eidx[x]++;
          m_pos++;
          phase_beats++;
          if (ex_last) begin
            if (x == 0) m_cnt0 = (m_cnt0 + 1) % CMOD;
            else        m_cnt1 = (m_cnt1 + 1) % CMOD;
            m_last  = x;
            m_owner = -1;
            m_pos   = 0;
            trunc_n = !src_last;
          end
        end
      end
    end
    m_trunc = trunc_n;
    if (rst) model_reset();
  endtask

  task automatic run(int cycles, int pv0, int pv1, int pr, int rst_beat);
    bit fired;
    fired = 1'b0;
    phase_beats = 0;
    tpulse = 0;
    drive(pv0, pv1, pr);
    repeat (cycles) begin
      @(negedge aclk);
      observe();
      @(posedge aclk);
      #1;
      for (int x = 0; x < 2; x++) if (hs[x]) idx[x]++;
      rst = 1'b0;
      if (rst_beat > 0 && !fired && phase_beats == rst_beat - 1) begin
        rst   = 1'b1;
        fired = 1'b1;
      end
      drive(pv0, pv1, pr);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    slen[0] = 0;
    slen[1] = 0;
    idx[0] = 0;
    idx[1] = 0;
    drive(0, 0, 0);
    repeat (2) @(posedge aclk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    do_reset();
    load(0, 4, 4, 10);
    load(1, 0, 1, 0);
    run(12, 100, 100, 100, 0);
    chk("t1_beats", 64'(eidx[0]), 64'(4));
    chk("t1_count0", 64'(pkt_count0), 64'(1));

    do_reset();
    load(0, 12, 3, 100);
    load(1, 12, 3, 200);
    run(50, 100, 100, 100, 0);
    chk("t2_counts_equal", 64'(pkt_count0), 64'(pkt_count1));
    chk("t2_count1", 64'(pkt_count1), 64'(4));

    do_reset();
    load(0, 3, 3, 300);
    load(1, 20, 0, 400);
    run(45, 100, 100, 100, 0);
    chk("t3_beats", 64'(eidx[1]), 64'(20));
    chk("t3_trunc_pulses", 64'(tpulse), 64'(2));
    chk("t3_count1", 64'(pkt_count1), 64'(2));

    do_reset();
    load(0, 5, 5, 500);
    load(1, 5, 5, 600);
    run(200, 100, 100, 25, 0);
    chk("t4_beats0", 64'(eidx[0]), 64'(5));
    chk("t4_beats1", 64'(eidx[1]), 64'(5));

    do_reset();
    load(0, 4, 4, 700);
    load(1, 2, 2, 800);
    run(20, 100, 100, 100, 2);
    chk("t5_beats0", 64'(eidx[0]), 64'(4));
    chk("t5_count0", 64'(pkt_count0), 64'(1));

    do_reset();
    load(0, 17, 1, 900);
    run(60, 100, 100, 100, 0);
    chk("t6_beats", 64'(eidx[0]), 64'(17));
    chk("t6_wrap", 64'(pkt_count0), 64'(1));

    for (int r = 0; r < 3; r++) begin
      do_reset();
      load(0, 80, -1, -1);
      load(1, 80, -1, -1);
      run(1200, 70, 60, 55, 0);
      run(300, 100, 100, 100, 0);
      chk("rand_beats0", 64'(eidx[0]), 64'(80));
      chk("rand_beats1", 64'(eidx[1]), 64'(80));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
